muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
- Parametrised, sequential successor to the combinational decode control unit: owns the HI/LO instruction class (mult/multu/div/divu/madd/msub/mthi/mtlo/mfhi/mflo).
- Decodes the ID-stage instruction, launches the multi-cycle mul/div datapath and tracks its latency with a counter FSM.
- Issues the HI/LO write strobe and stalls the pipeline front end on HI/LO structural or data hazards.
- Replaces the single "en" bit of the main control unit for this instruction class.

Parameters:
MUL_LAT, 4, cycles from start pulse to result valid for mult/multu/madd/msub (>=1)
DIV_LAT, 32, cycles from start pulse to result valid for div/divu (>=1)
CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID-stage instruction valid
flush  in  1  kill ID-stage instruction this cycle (masks id_valid)
Opcode  in  6  ID instruction [31:26]
Function  in  6  ID instruction [5:0]
stall  out  1  hold PC and IF/ID, insert bubble (combinational)
md_start  out  1  one-cycle launch pulse to mul/div datapath
md_op  out  3  latched op: 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 msub
hilo_we  out  2  write strobe {HI, LO}
hilo_src  out  1  0 = mul/div result, 1 = GPR rs (mthi/mtlo)
busy  out  1  high in BUSY or DONE

Behaviour:
- Reset (async, rst_n low): state IDLE, counter 0, md_op 0; md_start, hilo_we, hilo_src, busy all 0.
- Decode, with v = id_valid & ~flush:
  - START class: Opcode 000000 with Function 011000/011001/011010/011011; Opcode 011100 with Function 000000/000100.
  - MT class: Opcode 000000 with Function 010001 (mthi) / 010011 (mtlo).
  - MF class: Opcode 000000 with Function 010000 (mfhi) / 010010 (mflo).
  - Any other instruction: no effect, never stalls.
- FSM states IDLE, BUSY, DONE.
  - IDLE:
    - v & START: md_start=1 that cycle, md_op latched, counter <= LAT-1 (MUL_LAT or DIV_LAT), next BUSY.
    - v & MT: hilo_we=10 (mthi) or 01 (mtlo), hilo_src=1, same cycle; stay IDLE.
    - MF: no stall.
  - BUSY: counter decrements by 1 each cycle; at counter==0 next is DONE. LAT=1 gives exactly one BUSY cycle.
  - DONE (one cycle): hilo_we=11, hilo_src=0.
    - v & START: accepted back-to-back (md_start=1, reload counter, next BUSY); otherwise next IDLE.
- Latency: md_start at cycle T gives hilo_we=11 at cycle T+LAT+1.
- stall = v & (START|MT|MF) & ((state==BUSY) | (state==DONE & (MT|MF))).
  - MF in DONE stalls because HI/LO is written at the end of that cycle; MF issues the following cycle.
  - MT in BUSY/DONE stalls so the GPR write cannot be overwritten by the pending result.
  - A stalled instruction produces no md_start and no MT strobe.
- flush during BUSY does not cancel the in-flight op; flush only masks the ID instruction.
- rst_n asserted mid-operation: immediate IDLE, the pending result is discarded, no hilo_we.
- Outputs md_start, hilo_we, hilo_src, stall are combinational from state and decode; md_op and the counter are registered.

Test Plan:
- Reset: rst_n=0 mid-BUSY -> all outputs 0 asynchronously, state IDLE; release, then mflo issues with stall=0.
- mult (Op 000000, Fn 011000) at T0 with MUL_LAT=4 -> md_start=1, md_op=0 at T0; busy T1-T5; hilo_we=11, hilo_src=0 at T5; state IDLE at T6.
- div at T0 then mflo at T1 (DIV_LAT=32) -> stall=1 from T1 through T33, hilo_we=11 at T33; mflo issues at T34 with stall=0.
- Back-to-back: second mult presented during DONE -> md_start=1 in the same cycle as hilo_we=11; second result strobe 5 cycles later.
- mthi in IDLE -> hilo_we=10, hilo_src=1, stall=0. mtlo during BUSY -> stall=1 until IDLE, then hilo_we=01.
- flush=1 with madd (Op 011100, Fn 000000) in IDLE -> no md_start, no stall. Rerun with MUL_LAT=1 -> BUSY one cycle, hilo_we at T2.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO instruction-class control: decodes mult/div/madd/msub/mthi/mtlo/mfhi/mflo,
// launches the multi-cycle mul/div datapath, strobes HI/LO writes and stalls on hazards.
module muldiv_hilo_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic       flush,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function,
  output logic       stall,
  output logic       md_start,
  output logic [2:0] md_op,
  output logic [1:0] hilo_we,
  output logic       hilo_src,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic             v;
  logic             is_start, is_mt, is_mf, mt_hi;
  logic [2:0]       dec_op;
  logic [CNT_W-1:0] lat_load;

  assign v = id_valid & ~flush;

  always_comb begin
    is_start = 1'b0;
    is_mt    = 1'b0;
    is_mf    = 1'b0;
    mt_hi    = 1'b0;
    dec_op   = 3'd0;
    if (Opcode == 6'b000000) begin
      case (Function)
        6'b011000: begin is_start = 1'b1; dec_op = 3'd0; end
        6'b011001: begin is_start = 1'b1; dec_op = 3'd1; end
        6'b011010: begin is_start = 1'b1; dec_op = 3'd2; end
        6'b011011: begin is_start = 1'b1; dec_op = 3'd3; end
        6'b010001: begin is_mt = 1'b1; mt_hi = 1'b1; end
        6'b010011: is_mt = 1'b1;
        6'b010000, 6'b010010: is_mf = 1'b1;
        default: ;
      endcase
    end else if (Opcode == 6'b011100) begin
      case (Function)
        6'b000000: begin is_start = 1'b1; dec_op = 3'd4; end
        6'b000100: begin is_start = 1'b1; dec_op = 3'd5; end
        default: ;
      endcase
    end
  end

  assign lat_load = ((dec_op == 3'd2) || (dec_op == 3'd3)) ? DIV_LOAD : MUL_LOAD;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    md_start = 1'b0;
    hilo_we  = 2'b00;
    hilo_src = 1'b0;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (v && is_start) begin
          md_start = 1'b1;
          op_d     = dec_op;
          cnt_d    = lat_load;
          state_d  = BUSY;
        end else if (v && is_mt) begin
          hilo_we  = mt_hi ? 2'b10 : 2'b01;
          hilo_src = 1'b1;
        end
      end
      BUSY: begin
        stall = v & (is_start | is_mt | is_mf);
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        // HI/LO is written at the end of this cycle, so readers and GPR writers wait one cycle.
        hilo_we = 2'b11;
        stall   = v & (is_mt | is_mf);
        if (v && is_start) begin
          md_start = 1'b1;
          op_d     = dec_op;
          cnt_d    = lat_load;
          state_d  = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign md_op = op_q;
  assign busy  = (state_q == BUSY) || (state_q == DONE);

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Two configurations share one stimulus stream; a timestamp-based model predicts
// when each launched operation writes HI/LO and what every output must be.
module tb_muldiv_hilo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, flush;
  logic [5:0] Opcode, Function;

  logic       stall_w    [2];
  logic       md_start_w [2];
  logic [2:0] md_op_w    [2];
  logic [1:0] hilo_we_w  [2];
  logic       hilo_src_w [2];
  logic       busy_w     [2];

  int mul_lat [2] = '{4, 1};
  int div_lat [2] = '{32, 3};

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  int         done_at [2];
  logic [2:0] mop     [2];
  logic       e_start [2];
  logic [2:0] e_op;
  logic       last_stall0;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .flush(flush),
    .Opcode(Opcode), .Function(Function), .stall(stall_w[0]),
    .md_start(md_start_w[0]), .md_op(md_op_w[0]), .hilo_we(hilo_we_w[0]),
    .hilo_src(hilo_src_w[0]), .busy(busy_w[0])
  );

  muldiv_hilo_ctrl #(.MUL_LAT(1), .DIV_LAT(3), .CNT_W(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .flush(flush),
    .Opcode(Opcode), .Function(Function), .stall(stall_w[1]),
    .md_start(md_start_w[1]), .md_op(md_op_w[1]), .hilo_we(hilo_we_w[1]),
    .hilo_src(hilo_src_w[1]), .busy(busy_w[1])
  );

  // {Opcode, Function} of every instruction in the class, in op-code order then MT/MF.
  logic [11:0] itab [10] = '{
    {6'b000000, 6'b011000}, {6'b000000, 6'b011001}, {6'b000000, 6'b011010},
    {6'b000000, 6'b011011}, {6'b011100, 6'b000000}, {6'b011100, 6'b000100},
    {6'b000000, 6'b010001}, {6'b000000, 6'b010011},
    {6'b000000, 6'b010000}, {6'b000000, 6'b010010}
  };

  // cls: 0 other, 1 start, 2 mthi/mtlo, 3 mfhi/mflo
  task automatic decode_ref(input logic [5:0] op, input logic [5:0] fn,
                            output int cls, output logic [2:0] mop_o, output logic hi);
    cls = 0; mop_o = 3'd0; hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ({op, fn} == itab[i]) begin
        if (i < 6) begin cls = 1; mop_o = 3'(i); end
        else if (i < 8) begin cls = 2; hi = (i == 6); end
        else cls = 3;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    int         cls;
    logic [2:0] op;
    logic       hi, v, in_done, in_busy, e_stall, e_src;
    logic [1:0] e_we;
    v = id_valid & ~flush;
    decode_ref(Opcode, Function, cls, op, hi);
    e_op = op;
    for (int k = 0; k < 2; k++) begin
      in_done = (done_at[k] == cyc);
      in_busy = (done_at[k] > cyc);
      e_stall = v && (cls != 0) && (in_busy || (in_done && cls >= 2));
      e_start[k] = v && (cls == 1) && !in_busy;
      e_we  = 2'b00;
      e_src = 1'b0;
      if (in_done) e_we = 2'b11;
      else if (v && cls == 2 && !in_busy) begin
        e_we  = hi ? 2'b10 : 2'b01;
        e_src = 1'b1;
      end
      check($sformatf("d%0d_stall", k),    8'(stall_w[k]),    8'(e_stall));
      check($sformatf("d%0d_md_start", k), 8'(md_start_w[k]), 8'(e_start[k]));
      check($sformatf("d%0d_hilo_we", k),  8'(hilo_we_w[k]),  8'(e_we));
      check($sformatf("d%0d_hilo_src", k), 8'(hilo_src_w[k]), 8'(e_src));
      check($sformatf("d%0d_busy", k),     8'(busy_w[k]),     8'(in_done || in_busy));
      check($sformatf("d%0d_md_op", k),    8'(md_op_w[k]),    8'(mop[k]));
    end
    last_stall0 = stall_w[0];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      done_at[k] = -1;
      mop[k]     = 3'd0;
    end
  endtask

  task automatic step(input logic v, input logic fl, input logic [11:0] ins);
    @(negedge clk);
    id_valid = v; flush = fl; {Opcode, Function} = ins;
    #1;
    check_all();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (e_start[k]) begin
        done_at[k] = cyc + (((e_op == 3'd2) || (e_op == 3'd3)) ? div_lat[k] : mul_lat[k]) + 1;
        mop[k]     = e_op;
      end
    end
    cyc++;
  endtask

  localparam logic [11:0] I_MULT = {6'b000000, 6'b011000};
  localparam logic [11:0] I_DIV  = {6'b000000, 6'b011010};
  localparam logic [11:0] I_MADD = {6'b011100, 6'b000000};
  localparam logic [11:0] I_MTHI = {6'b000000, 6'b010001};
  localparam logic [11:0] I_MTLO = {6'b000000, 6'b010011};
  localparam logic [11:0] I_MFLO = {6'b000000, 6'b010010};
  localparam logic [11:0] I_NOP  = 12'h000;

  initial begin
    int n;
    logic [11:0] ins;
    rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; Opcode = '0; Function = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    8'(busy_w[0]),    8'd0);
    check("rst_hilo_we", 8'(hilo_we_w[0]), 8'd0);
    check("rst_md_op",   8'(md_op_w[0]),   8'd0);
    rst_n = 1'b1;

    // mult with 4-cycle latency, then back-to-back mult issued in DONE
    step(1, 0, I_MULT);
    repeat (4) step(0, 0, I_NOP);
    step(1, 0, I_MULT);
    repeat (6) step(0, 0, I_NOP);

    // mthi in IDLE, mtlo during BUSY held until the strobe lands
    step(1, 0, I_MTHI);
    step(1, 0, I_MULT);
    repeat (7) step(1, 0, I_MTLO);

    // flushed madd is ignored; then madd exercises the one-cycle multiply config
    step(1, 1, I_MADD);
    step(1, 0, I_MADD);
    repeat (6) step(0, 0, I_NOP);

    // div followed by mflo: stall must cover T1..T33
    step(1, 0, I_DIV);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step(1, 0, I_MFLO);
      if (!last_stall0) break;
      n++;
    end
    check("div_mflo_stall_cycles", 8'(n), 8'd33);

    // asynchronous reset in the middle of a multiply
    step(1, 0, I_MULT);
    step(1, 0, I_MFLO);
    @(negedge clk);
    id_valid = 1'b1; flush = 1'b0; {Opcode, Function} = I_MFLO;
    #2 rst_n = 1'b0;
    #1;
    check("arst_stall",    8'(stall_w[0]),    8'd0);
    check("arst_busy",     8'(busy_w[0]),     8'd0);
    check("arst_hilo_we",  8'(hilo_we_w[0]),  8'd0);
    check("arst_md_start", 8'(md_start_w[0]), 8'd0);
    check("arst_hilo_src", 8'(hilo_src_w[0]), 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, I_MFLO);
    repeat (3) step(0, 0, I_NOP);

    // random mix of class and unrelated instructions
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 12) < 10) ins = itab[$urandom_range(0, 9)];
      else ins = 12'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, ins);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
